// File: rtl/inst_fetch_unit.sv
// Purpose : owns the PC, fetches one instruction at a time and holds it in IR until the datapath retires it.
// Latency : a capture lands in IR at the edge where imem_ready=1; the earliest refetch follows a retire by one cycle.
// Backpressure: a stalled memory (imem_ready=0) holds the request and address indefinitely; IR is held until retire.
//
// Ports:
//   clk, rst             single rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr   fetch request and address (address is always pc)
//   imem_rdata/ready     instruction word and its valid strobe from memory
//   inst/opcode/func     held instruction register and its controller-facing slices
//   inst_valid           IR holds an instruction that has not yet retired
//   retire               datapath completes the IR instruction this cycle (ignored while fetching)
//   pc_src/pc_src2       next-PC select from the controller (branch taken / seq,jump,jr,reserved)
//   imm_sext/rs_data     branch offset and jr target operands from the datapath
//   pc/pc_plus4          current PC and its sequential successor (jal link value)
//   misalign_err         sticky flag: a jr target had nonzero low bits
//   retired_cnt          free-running count of retired instructions, wraps

module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   // instruction memory
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   // instruction to controller / datapath
   output logic [31:0]      inst,
   output logic [5:0]       opcode,
   output logic [5:0]       func,
   output logic             inst_valid,
   // retire and next-PC control
   input  logic             retire,
   input  logic             pc_src,
   input  logic [1:0]       pc_src2,
   input  logic [31:0]      imm_sext,
   input  logic [31:0]      rs_data,
   // PC and status
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             misalign_err,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [1:0] SRC2_SEQ  = 2'd0;
   localparam logic [1:0] SRC2_JUMP = 2'd1;
   localparam logic [1:0] SRC2_JR   = 2'd2;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic        misalign_q;
   logic [CNT_W-1:0] cnt_q;

   logic        capture;     // IR load strobe
   logic        do_retire;   // retire qualified by HOLD
   logic [31:0] next_pc;
   logic        jr_misalign;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      capture    = 1'b0;
      do_retire  = 1'b0;
      case (state)
         FETCH: begin
            // Request stays up until memory answers; no timeout.
            imem_req = 1'b1;
            if (imem_ready) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            inst_valid = 1'b1;
            if (retire) begin
               do_retire = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Next-PC selection, evaluated in the retire cycle.
   // A nonzero pc_src2 overrides a taken branch; code 3 falls back to
   // sequential. The branch add wraps modulo 2^32 by construction.
   // ------------------------------------------------------------------
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      next_pc     = pc_plus4;
      jr_misalign = 1'b0;
      case (pc_src2)
         SRC2_JUMP: begin
            next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
         end
         SRC2_JR: begin
            // Low bits are dropped from the target but remembered as an error.
            next_pc     = {rs_data[31:2], 2'b00};
            jr_misalign = |rs_data[1:0];
         end
         SRC2_SEQ: begin
            if (pc_src) begin
               next_pc = pc_plus4 + (imm_sext << 2);
            end
         end
         default: begin
            next_pc = pc_plus4;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // PC, instruction register, sticky error and retire counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         ir_q       <= 32'd0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (capture) begin
            ir_q <= imem_rdata;
         end
         if (do_retire) begin
            pc_q  <= next_pc;
            cnt_q <= cnt_q + CNT_W'(1);
            if (jr_misalign) begin
               misalign_q <= 1'b1;
            end
         end
      end
   end

   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign inst         = ir_q;
   assign opcode       = ir_q[31:26];
   assign func         = ir_q[5:0];
   assign misalign_err = misalign_q;
   assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Purpose : scoreboard bench for inst_fetch_unit; the model pushes each expected fetch address when a retire is driven.
// Latency : stimulus is applied 1ns after a rising edge; outputs are sampled at the same point, before new drive.
// Backpressure: the bench memory answers combinationally; imem_ready is withheld for chosen stall lengths.

module tb_inst_fetch_unit;

   localparam int          CW  = 4;   // small counter so wrap is reachable quickly
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic          clk;
   logic          rst;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          imem_ready;
   logic [31:0]   inst;
   logic [5:0]    opcode;
   logic [5:0]    func;
   logic          inst_valid;
   logic          retire;
   logic          pc_src;
   logic [1:0]    pc_src2;
   logic [31:0]   imm_sext;
   logic [31:0]   rs_data;
   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic          misalign_err;
   logic [CW-1:0] retired_cnt;

   inst_fetch_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .inst         (inst),
      .opcode       (opcode),
      .func         (func),
      .inst_valid   (inst_valid),
      .retire       (retire),
      .pc_src       (pc_src),
      .pc_src2      (pc_src2),
      .imm_sext     (imm_sext),
      .rs_data      (rs_data),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .misalign_err (misalign_err),
      .retired_cnt  (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench memory: word derived from address unless an override is armed.
   logic        ov_en;
   logic [31:0] ov_word;
   assign imem_rdata = ov_en ? ov_word : {6'h23, imem_addr[27:2]};

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Model state
   logic [31:0]   exp_q[$];
   logic [31:0]   m_pc;
   logic [31:0]   m_inst;
   logic [CW-1:0] m_cnt;
   logic          m_mis;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      retire   = 1'b0;
      pc_src   = 1'b0;
      pc_src2  = 2'd0;
      m_pc     = RPC;
      m_inst   = 32'd0;
      m_cnt    = '0;
      m_mis    = 1'b0;
      exp_q.delete();
      exp_q.push_back(RPC);
      check("rst_pc",       pc,           RPC);
      check("rst_inst",     inst,         32'd0);
      check("rst_opcode",   32'(opcode),  32'd0);
      check("rst_func",     32'(func),    32'd0);
      check("rst_valid",    32'(inst_valid), 32'd0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      check("rst_cnt",      32'(retired_cnt), 32'd0);
      check("rst_req",      32'(imem_req), 32'd1);
      check("rst_addr",     imem_addr,    RPC);
      check("rst_pc4",      pc_plus4,     RPC + 32'd4);
   endtask

   // One fetch: optional stall cycles (with a stray retire if asked), then capture.
   task automatic fetch(input int waits, input bit stray_retire);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
         e = m_pc;
      end else begin
         e = exp_q.pop_front();
      end
      check("fetch_addr",  imem_addr, e);
      check("fetch_req",   32'(imem_req), 32'd1);
      check("fetch_valid", 32'(inst_valid), 32'd0);
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         retire     = stray_retire;
         pc_src2    = 2'd1;
         tick();
         check("wait_req",   32'(imem_req), 32'd1);
         check("wait_addr",  imem_addr, e);
         check("wait_valid", 32'(inst_valid), 32'd0);
         check("wait_cnt",   32'(retired_cnt), 32'(m_cnt));
      end
      retire     = 1'b0;
      pc_src2    = 2'd0;
      imem_ready = 1'b1;
      m_inst     = ov_en ? ov_word : {6'h23, e[27:2]};
      tick();
      imem_ready = 1'b0;
      check("cap_valid",  32'(inst_valid), 32'd1);
      check("cap_req",    32'(imem_req), 32'd0);
      check("cap_inst",   inst, m_inst);
      check("cap_opcode", 32'(opcode), 32'(m_inst[31:26]));
      check("cap_func",   32'(func),   32'(m_inst[5:0]));
   endtask

   // Retire the held instruction; the model computes the next PC and queues it.
   task automatic do_retire(input logic src, input logic [1:0] src2,
                            input logic [31:0] imm, input logic [31:0] rs, input int idle);
      logic [31:0] p4;
      logic [31:0] nxt;
      for (int i = 0; i < idle; i++) begin
         tick();
         check("hold_valid", 32'(inst_valid), 32'd1);
         check("hold_inst",  inst, m_inst);
         check("hold_pc",    pc, m_pc);
      end
      p4 = m_pc + 32'd4;
      check("pc_plus4", pc_plus4, p4);
      if (src2 == 2'd1)      nxt = {p4[31:28], m_inst[25:0], 2'b00};
      else if (src2 == 2'd2) begin
         nxt = {rs[31:2], 2'b00};
         if (rs[1:0] != 2'b00) m_mis = 1'b1;
      end
      else if (src2 == 2'd0 && src) nxt = p4 + {imm[29:0], 2'b00};
      else                          nxt = p4;
      pc_src   = src;
      pc_src2  = src2;
      imm_sext = imm;
      rs_data  = rs;
      retire   = 1'b1;
      tick();
      retire  = 1'b0;
      pc_src  = 1'b0;
      pc_src2 = 2'd0;
      m_pc    = nxt;
      m_cnt   = m_cnt + 1'b1;
      exp_q.push_back(nxt);
      check("ret_pc",       pc, m_pc);
      check("ret_cnt",      32'(retired_cnt), 32'(m_cnt));
      check("ret_misalign", 32'(misalign_err), 32'(m_mis));
      check("ret_valid",    32'(inst_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; retire = 1'b0; pc_src = 1'b0; pc_src2 = 2'd0;
      imm_sext = 32'd0; rs_data = 32'd0; imem_ready = 1'b0;
      ov_en = 1'b0; ov_word = 32'd0;

      do_reset();

      // Sequential stream 0,4,8,C with zero-wait memory
      fetch(0, 0); do_retire(0, 2'd0, 32'd0, 32'd0, 0);
      fetch(0, 0); do_retire(0, 2'd0, 32'd0, 32'd0, 1);
      fetch(0, 0); do_retire(0, 2'd0, 32'd0, 32'd0, 0);
      check("cnt_after3", 32'(retired_cnt), 32'd3);

      // Stalled memory at 0xC; a stray retire during the stall must do nothing
      fetch(3, 1); do_retire(0, 2'd0, 32'd0, 32'd0, 0);

      // Backward branch from 0x10 to 0x0C
      fetch(0, 0); do_retire(1, 2'd0, 32'hFFFF_FFFE, 32'd0, 0);
      check("branch_pc", pc, 32'h0000_000C);

      // Jump with pc_src also high: jump wins, target 0x100
      ov_en = 1'b1; ov_word = {6'h02, 26'h40};
      fetch(0, 0);
      ov_en = 1'b0;
      do_retire(1, 2'd1, 32'hFFFF_FFFE, 32'd0, 0);
      check("jump_pc", pc, 32'h0000_0100);

      // Misaligned jr, then sticky across later retires
      fetch(0, 0); do_retire(0, 2'd2, 32'd0, 32'h0000_0203, 0);
      check("jr_pc", pc, 32'h0000_0200);
      fetch(1, 0); do_retire(0, 2'd0, 32'd0, 32'd0, 0);
      fetch(0, 0); do_retire(1, 2'd3, 32'h0000_0100, 32'd0, 0);
      check("reserved_pc", pc, 32'h0000_0208);

      // PC wrap at the top of the address space
      fetch(0, 0); do_retire(0, 2'd2, 32'd0, 32'hFFFF_FFFC, 0);
      fetch(0, 0);
      check("wrap_pc4", pc_plus4, 32'd0);
      do_retire(0, 2'd0, 32'd0, 32'd0, 0);
      check("wrap_pc", pc, 32'd0);
      fetch(0, 0); do_retire(0, 2'd0, 32'd0, 32'd0, 0);
      check("sticky_mis", 32'(misalign_err), 32'd1);

      // Reset during a FETCH stall, with retire asserted alongside
      check("pre_rst_addr", imem_addr, exp_q[0]);
      imem_ready = 1'b0; retire = 1'b1; pc_src2 = 2'd1;
      tick();
      check("stall_addr", imem_addr, 32'h0000_0004);
      do_reset();

      // Reset during HOLD with a misaligned jr retire in the same cycle
      fetch(0, 0);
      retire = 1'b1; pc_src2 = 2'd2; rs_data = 32'h0000_0003;
      do_reset();

      // Long sequential run to wrap the retire counter
      for (int k = 0; k < 17; k++) begin
         fetch(k % 2, 0);
         do_retire(0, 2'd0, 32'd0, 32'd0, 0);
      end
      check("cnt_wrap", 32'(retired_cnt), 32'd1);
      fetch(0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
